valet_retrieval_ctrl: RTL and testbench

//  - Retrieval-side counterpart to the arrival path: holds the lot occupancy table fed by park events,

---
 rtl/valet_retrieval_ctrl.sv | 149 ++++++++++++++
 tb/tb_valet_retrieval_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/valet_retrieval_ctrl.sv
// valet_retrieval_ctrl: lot occupancy table, retrieval request queue and walk/handoff FSM.
// Optional VIP-first request selection is enabled by defining VALET_VIP_PRIORITY_EN.
module valet_retrieval_ctrl #(
    parameter int NUM_SLOTS   = 8,
    parameter int PLATE_W     = 16,
    parameter int CNT_W       = 16,
    parameter int WALK_CYCLES = 4,
    parameter int REQ_DEPTH   = 4,
    localparam int SLOT_W     = $clog2(NUM_SLOTS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               park_valid,
    output logic               park_ready,
    input  logic [PLATE_W-1:0] park_plate,
    output logic               park_dup,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [PLATE_W-1:0] req_plate,
    input  logic               req_vip,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PLATE_W-1:0] out_plate,
    output logic [SLOT_W-1:0]  out_slot,
    output logic               out_miss,
    output logic [CNT_W-1:0]   out_wait,
    output logic [SLOT_W:0]    slots_used
);
    localparam int QI = $clog2(REQ_DEPTH);
    localparam int QW = $clog2(REQ_DEPTH + 1);
    localparam int WW = $clog2(WALK_CYCLES + 1);
`ifdef VALET_VIP_PRIORITY_EN
    localparam bit VIP_EN = 1'b1;
`else
    localparam bit VIP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOOKUP, WALK, HANDOFF} state_t;
    state_t state, state_nxt;

    logic [NUM_SLOTS-1:0] occ;
    logic [PLATE_W-1:0]   slot_plate [NUM_SLOTS];
    logic [PLATE_W-1:0]   q_plate [REQ_DEPTH];
    logic                 q_vip   [REQ_DEPTH];
    logic [CNT_W-1:0]     q_age   [REQ_DEPTH];
    logic [PLATE_W-1:0]   nq_plate [REQ_DEPTH];
    logic                 nq_vip   [REQ_DEPTH];
    logic [CNT_W-1:0]     nq_age   [REQ_DEPTH];
    logic [QW-1:0]        q_cnt, wpos;
    logic [QI-1:0]        sel, j;
    logic [WW-1:0]        walk_cnt;
    logic [CNT_W-1:0]     wait_cnt, lk_age;
    logic [PLATE_W-1:0]   lk_plate;
    logic [SLOT_W-1:0]    lk_slot, free_idx;
    logic                 lk_hit, park_hit, park_fire, req_fire, pop, out_fire;

    assign park_ready = ~&occ;
    assign park_fire  = park_valid && park_ready;
    assign req_ready  = q_cnt < QW'(REQ_DEPTH);
    assign req_fire   = req_valid && req_ready;
    assign pop        = state == LOOKUP;
    assign out_valid  = state == HANDOFF;
    assign out_fire   = out_valid && out_ready;
    assign out_wait   = wait_cnt;
    assign lk_plate   = q_plate[sel];
    assign lk_age     = q_age[sel];
    assign wpos       = q_cnt - QW'(pop);

    // Table is read pre-write: a park landing this cycle is invisible to lookup and dup checks.
    always_comb begin
        lk_hit     = 1'b0;
        lk_slot    = '0;
        park_hit   = 1'b0;
        free_idx   = '0;
        slots_used = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (occ[i] && slot_plate[i] == lk_plate) begin
                lk_hit  = 1'b1;
                lk_slot = SLOT_W'(i);
            end
            if (occ[i] && slot_plate[i] == park_plate) park_hit = 1'b1;
            if (!occ[i]) free_idx = SLOT_W'(i);
            slots_used = slots_used + {{SLOT_W{1'b0}}, occ[i]};
        end
    end

    // Queue is a compacting shift list so a VIP entry can leave from the middle.
    always_comb begin
        sel = '0;
        for (int i = REQ_DEPTH - 1; i >= 0; i--)
            if (VIP_EN && QW'(i) < q_cnt && q_vip[i]) sel = QI'(i);
        for (int i = 0; i < REQ_DEPTH; i++) begin
            j = (pop && QI'(i) >= sel && i < REQ_DEPTH - 1) ? QI'(i + 1) : QI'(i);
            nq_plate[i] = req_fire && QW'(i) == wpos ? req_plate : q_plate[j];
            nq_vip[i]   = req_fire && QW'(i) == wpos ? req_vip & VIP_EN : q_vip[j];
            nq_age[i]   = req_fire && QW'(i) == wpos ? '0 :
                          &q_age[j] ? q_age[j] : q_age[j] + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = |q_cnt ? LOOKUP : IDLE;
            LOOKUP:  state_nxt = lk_hit ? WALK : HANDOFF;
            WALK:    state_nxt = walk_cnt == WW'(WALK_CYCLES - 1) ? HANDOFF : WALK;
            HANDOFF: state_nxt = out_ready ? IDLE : HANDOFF;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            occ       <= '0;
            q_cnt     <= '0;
            park_dup  <= 1'b0;
            out_plate <= '0;
            out_slot  <= '0;
            out_miss  <= 1'b0;
            wait_cnt  <= '0;
            walk_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            q_cnt    <= q_cnt + QW'(req_fire) - QW'(pop);
            park_dup <= park_fire && park_hit;
            if (park_fire && !park_hit) occ[free_idx] <= 1'b1;
            if (out_fire && !out_miss) occ[out_slot] <= 1'b0;
            if (pop) begin
                out_plate <= lk_plate;
                out_slot  <= lk_hit ? lk_slot : '0;
                out_miss  <= !lk_hit;
                wait_cnt  <= &lk_age ? lk_age : lk_age + CNT_W'(1);
                walk_cnt  <= '0;
            end
            if (state == WALK) begin
                walk_cnt <= walk_cnt + WW'(1);
                wait_cnt <= &wait_cnt ? wait_cnt : wait_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (park_fire && !park_hit) slot_plate[free_idx] <= park_plate;
        q_plate <= nq_plate;
        q_vip   <= nq_vip;
        q_age   <= nq_age;
    end
endmodule

// File: tb/tb_valet_retrieval_ctrl.sv
// tb_valet_retrieval_ctrl: directed checks of park, retrieval, miss, full lot, stall, reset and ordering.
module tb_valet_retrieval_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        park_valid = 1'b0, park_ready, park_dup;
    logic [15:0] park_plate = '0;
    logic        req_valid = 1'b0, req_ready, req_vip = 1'b0;
    logic [15:0] req_plate = '0;
    logic        out_valid, out_ready = 1'b1, out_miss;
    logic [15:0] out_plate, out_wait;
    logic [2:0]  out_slot;
    logic [3:0]  slots_used;
    int          passed = 0, total = 0;

    valet_retrieval_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .park_valid(park_valid), .park_ready(park_ready), .park_plate(park_plate), .park_dup(park_dup),
        .req_valid(req_valid), .req_ready(req_ready), .req_plate(req_plate), .req_vip(req_vip),
        .out_valid(out_valid), .out_ready(out_ready), .out_plate(out_plate), .out_slot(out_slot),
        .out_miss(out_miss), .out_wait(out_wait), .slots_used(slots_used)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    task automatic park(input logic [15:0] p);
        park_valid = 1'b1;
        park_plate = p;
        tick();
        park_valid = 1'b0;
    endtask

    task automatic req(input logic [15:0] p, input logic v);
        req_valid = 1'b1;
        req_plate = p;
        req_vip   = v;
        tick();
        req_valid = 1'b0;
        req_vip   = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("out_valid_seen", out_valid, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bit stable, seen;
        logic [15:0] pl [4] = '{16'd100, 16'd201, 16'd202, 16'd204};
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_miss", out_miss, 0);
        chk("rst_out_plate", out_plate, 0);
        chk("rst_out_wait", out_wait, 0);
        chk("rst_park_dup", park_dup, 0);
        chk("rst_used", slots_used, 0);
        chk("rst_park_ready", park_ready, 1);
        chk("rst_req_ready", req_ready, 1);

        park(100); park(105); park(110);
        chk("t1_used3", slots_used, 3);
        req(105, 0);
        wait_valid(n);
        chk("t1_latency", n, 6);
        chk("t1_plate", out_plate, 105);
        chk("t1_slot", out_slot, 1);
        chk("t1_miss", out_miss, 0);
        chk("t1_wait", out_wait, 6);
        tick();
        chk("t1_valid_drop", out_valid, 0);
        chk("t1_used2", slots_used, 2);

        req(999, 0);
        wait_valid(n);
        chk("t2_latency", n, 2);
        chk("t2_miss", out_miss, 1);
        chk("t2_slot", out_slot, 0);
        chk("t2_plate", out_plate, 999);
        chk("t2_wait", out_wait, 2);
        tick();
        chk("t2_used", slots_used, 2);

        do_reset();
        park(100);
        park(100);
        chk("t4_dup", park_dup, 1);
        chk("t4_used", slots_used, 1);
        tick();
        chk("t4_dup_clear", park_dup, 0);

        for (int i = 1; i < 8; i++) park(16'(200 + i));
        chk("t3_used8", slots_used, 8);
        chk("t3_full", park_ready, 0);
        out_ready = 1'b0;
        req(203, 0);
        wait_valid(n);
        chk("t3_latency", n, 6);
        chk("t3_slot", out_slot, 3);
        out_ready  = 1'b1;
        park_valid = 1'b1;
        park_plate = 300;
        chk("t3_full_at_free", park_ready, 0);
        tick();
        chk("t3_ready_after_free", park_ready, 1);
        chk("t3_used7", slots_used, 7);
        tick();
        park_valid = 1'b0;
        chk("t3_used8_again", slots_used, 8);

        out_ready = 1'b0;
        req(300, 0);
        wait_valid(n);
        chk("t5_latency", n, 6);
        chk("t5_slot_reuse", out_slot, 3);
        chk("t5_plate", out_plate, 300);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req_valid = i < 4;
            req_plate = pl[i % 4];
            tick();
            stable &= out_valid && out_plate == 300 && out_slot == 3 && !out_miss && out_wait == 6;
        end
        req_valid = 1'b0;
        chk("t5_stable", stable, 1);
        chk("t5_fifo_full", req_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("t5_used7", slots_used, 7);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_plate", out_plate, 0);
        chk("t5_rst_slot", out_slot, 0);
        chk("t5_rst_miss", out_miss, 0);
        chk("t5_rst_wait", out_wait, 0);
        chk("t5_rst_used", slots_used, 0);
        chk("t5_rst_req_ready", req_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen |= out_valid;
        end
        chk("t5_no_result", seen, 0);

        park(500);
        req(500, 0);
        req(120, 0);
        req(125, 1);
        req(130, 0);
        wait_valid(n);
        chk("t6_first", out_plate, 500);
        tick();
        wait_valid(n);
`ifdef VALET_VIP_PRIORITY_EN
        chk("t6_second", out_plate, 125);
        tick();
        wait_valid(n);
        chk("t6_third", out_plate, 120);
`else
        chk("t6_second", out_plate, 120);
        tick();
        wait_valid(n);
        chk("t6_third", out_plate, 125);
`endif
        tick();
        wait_valid(n);
        chk("t6_fourth", out_plate, 130);
        chk("t6_fourth_miss", out_miss, 1);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
